// File: rtl/anton_neopixel_stream_engine.sv
// NeoPixel stream sequencer: walks sub-bit, bit and pixel indices through the
// buffer, then holds the line in reset, with loop/one-shot control and frame counting.
module anton_neopixel_stream_engine #(
  parameter int unsigned BUFFER_END    = 7,
  parameter int unsigned RESET_DELAY   = 1959,
  parameter int unsigned PIXEL_BITS    = 24,
  parameter int unsigned PATTERN_STEPS = 8,
  parameter int unsigned BUFFER_BITS   = $clog2(BUFFER_END + 1)
) (
  input  logic                             clk6_4mhz,
  input  logic                             rst,
  input  logic                             reg_ctrl_init,
  input  logic                             reg_ctrl_run,
  input  logic                             reg_ctrl_loop,
  input  logic                             reg_ctrl_limit,
  input  logic                             reg_ctrl_32bit,
  input  logic [12:0]                      reg_max,
  input  logic [11:0]                      reg_reset_delay,
  input  logic                             init_slow,
  output logic                             init_slow_done,
  output logic [$clog2(PATTERN_STEPS)-1:0] bit_pattern_index,
  output logic [5:0]                       pixel_bit_index,
  output logic [BUFFER_BITS-1:0]           pixel_index,
  output logic [BUFFER_BITS-1:0]           pixel_index_max,
  output logic [1:0]                       state,
  output logic                             stream_output,
  output logic                             stream_reset,
  output logic                             stream_bit_of,
  output logic                             stream_pixel_of,
  output logic                             stream_sync_of,
  output logic                             frame_done,
  output logic [15:0]                      frame_count
);

  localparam int unsigned PAT_W = $clog2(PATTERN_STEPS);
  localparam logic [BUFFER_BITS-1:0] LOW_MASK = BUFFER_BITS'(3);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRANSMIT = 2'd1,
    ST_RESET    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PAT_W-1:0]       pat_q, pat_d;
  logic [5:0]             bit_q, bit_d;
  logic [BUFFER_BITS-1:0] pix_q, pix_d;
  logic [11:0]            rcnt_q, rcnt_d;
  logic [15:0]            fcnt_q, fcnt_d;
  logic                   fdone_q, fdone_d;
  logic                   ack_q, ack_d;

  logic                   active;
  logic                   pattern_of;
  logic                   last;
  logic [BUFFER_BITS-1:0] pix_equiv;
  logic [BUFFER_BITS-1:0] pix_step;
  logic [11:0]            delay_eff;
  logic [12:0]            max_clamped;

  // Clamp is done at full register width so large reg_max values cannot alias
  // onto small indices after truncation.
  always_comb begin
    max_clamped = (reg_max < 13'(BUFFER_END)) ? reg_max : 13'(BUFFER_END);
    pixel_index_max = reg_ctrl_limit ? max_clamped[BUFFER_BITS-1:0]
                                     : BUFFER_BITS'(BUFFER_END);
  end

  always_comb begin
    active          = reg_ctrl_run && !reg_ctrl_init;
    stream_output   = active && (state_q == ST_TRANSMIT);
    stream_reset    = active && (state_q == ST_RESET);
    pattern_of      = stream_output && (pat_q == PAT_W'(PATTERN_STEPS - 1));
    stream_bit_of   = pattern_of && (bit_q == 6'(PIXEL_BITS - 1));
    pix_equiv       = reg_ctrl_32bit ? (pix_q | LOW_MASK) : pix_q;
    last            = (pix_equiv == pixel_index_max);
    stream_pixel_of = stream_bit_of && last;
    pix_step        = reg_ctrl_32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1);
    delay_eff       = (reg_reset_delay != 12'd0) ? reg_reset_delay : 12'(RESET_DELAY);
    stream_sync_of  = stream_reset && (rcnt_q == delay_eff);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    rcnt_d  = rcnt_q;
    fcnt_d  = fcnt_q;
    fdone_d = 1'b0;
    ack_d   = 1'b0;

    if (init_slow) begin
      // Toggling the acknowledge makes a held request re-acknowledge every other cycle.
      state_d = ST_IDLE;
      pat_d   = '0;
      bit_d   = '0;
      pix_d   = '0;
      rcnt_d  = '0;
      ack_d   = !ack_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (active) begin
            state_d = ST_TRANSMIT;
            pat_d   = '0;
            bit_d   = '0;
            pix_d   = '0;
            rcnt_d  = '0;
          end
        end
        ST_TRANSMIT: begin
          if (stream_output) begin
            pat_d = pat_q + 1'b1;
            if (pattern_of) begin
              bit_d = stream_bit_of ? 6'd0 : bit_q + 6'd1;
            end
            if (stream_bit_of) begin
              pix_d = last ? '0 : pix_q + pix_step;
            end
            if (stream_pixel_of) begin
              state_d = ST_RESET;
            end
          end
        end
        ST_RESET: begin
          if (stream_reset) begin
            if (stream_sync_of) begin
              rcnt_d  = '0;
              fdone_d = 1'b1;
              fcnt_d  = fcnt_q + 16'd1;
              state_d = reg_ctrl_loop ? ST_TRANSMIT : ST_DONE;
            end else begin
              rcnt_d = rcnt_q + 12'd1;
            end
          end
        end
        ST_DONE: begin
          if (!reg_ctrl_run) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk6_4mhz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      rcnt_q  <= '0;
      fcnt_q  <= '0;
      fdone_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      rcnt_q  <= rcnt_d;
      fcnt_q  <= fcnt_d;
      fdone_q <= fdone_d;
      ack_q   <= ack_d;
    end
  end

  assign state             = state_q;
  assign bit_pattern_index = pat_q;
  assign pixel_bit_index   = bit_q;
  assign pixel_index       = pix_q;
  assign frame_count       = fcnt_q;
  assign frame_done        = fdone_q;
  assign init_slow_done    = ack_q;

endmodule

// File: doc/anton_neopixel_stream_engine.md
Name: anton_neopixel_stream_engine

Overview:
- Parametrised successor of the NeoPixel stream sequencer.
- Generates sub-bit, bit and pixel indices plus stream strobes for the pattern generator, in the clk6_4mhz domain.
- Adds the following over the previous generation:
  - configurable bits per pixel (RGB/RGBW)
  - configurable sub-bit step count
  - runtime reset-delay override
  - one-shot versus loop operation with an explicit DONE state
  - reg_max clamping
  - frame counter

Parameters:
- BUFFER_END, 7, last valid buffer byte index.
- RESET_DELAY, 1959, default reset-state length in ticks.
- PIXEL_BITS, 24, bits per pixel; legal values are 24 or 32.
- PATTERN_STEPS, 8, sub-bit steps per bit; must be a power of 2, from 2 to 16.
- BUFFER_BITS, CLOG2(BUFFER_END+1), derived; do not override.

Ports:
- clk6_4mhz  in  1  stream clock.
- rst  in  1  asynchronous, active-high reset.
- reg_ctrl_init  in  1  software init; freezes the stream.
- reg_ctrl_run  in  1  enable streaming.
- reg_ctrl_loop  in  1  1 = restart after reset period; 0 = one-shot.
- reg_ctrl_limit  in  1  use reg_max instead of BUFFER_END.
- reg_ctrl_32bit  in  1  32-bit addressing mode; pixel index steps by 4.
- reg_max  in  13  software pixel limit.
- reg_reset_delay  in  12  reset length override; 0 selects RESET_DELAY.
- init_slow  in  1  slow-domain init request.
- init_slow_done  out  1  one-cycle acknowledge.
- bit_pattern_index  out  CLOG2(PATTERN_STEPS)  sub-bit step.
- pixel_bit_index  out  6  bit within the pixel.
- pixel_index  out  BUFFER_BITS  current pixel byte index.
- pixel_index_max  out  BUFFER_BITS  effective last index.
- state  out  2  0=IDLE, 1=TRANSMIT, 2=RESET, 3=DONE.
- stream_output, stream_reset  out  1  active transmit / active reset.
- stream_bit_of, stream_pixel_of, stream_sync_of  out  1  overflow strobes.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_count  out  16  completed frames; wraps.

Behaviour:
- Reset values: all counters 0, state IDLE, all strobes 0, frame_count 0, init_slow_done 0.
- Priority: rst > init_slow > normal operation.
- active = run && !init.
- stream_output = active && state==TRANSMIT.
- stream_reset = active && state==RESET.
- If active drops mid-operation, all counters and state hold; streaming resumes from the same point when active returns.
- IDLE -> TRANSMIT when active, with all indices at 0.
- TRANSMIT counting:
  - bit_pattern_index increments on every stream_output cycle.
  - pattern_of = stream_output && bit_pattern_index==PATTERN_STEPS-1.
  - On pattern_of, pixel_bit_index increments, or wraps to 0 when it equals PIXEL_BITS-1. That wrap cycle is stream_bit_of.
- Pixel index:
  - pixel_index_equiv = 32bit ? {pixel_index[hi:2], 2'b11} : pixel_index.
  - last = (pixel_index_equiv == pixel_index_max).
  - On stream_bit_of: if last, pixel_index <= 0; otherwise pixel_index += 4 in 32-bit mode, += 1 in 8-bit mode.
  - stream_pixel_of = stream_bit_of && last; state -> RESET on the next edge.
- pixel_index_max:
  - limit=0: BUFFER_END.
  - limit=1: min(reg_max, BUFFER_END), compared at full 13-bit width before truncation.
- RESET state:
  - delay_eff = reg_reset_delay ? reg_reset_delay : RESET_DELAY; sampled every cycle.
  - The 12-bit counter increments on each stream_reset cycle.
  - stream_sync_of = stream_reset && count==delay_eff. The RESET state therefore lasts delay_eff+1 active cycles.
  - On stream_sync_of: counter <= 0, frame_done pulses, frame_count += 1.
  - Then state -> TRANSMIT if loop=1, or DONE if loop=0.
- DONE: all strobes are 0. Return to IDLE when run=0.
- If loop is cleared while in TRANSMIT, the current frame completes and the block then enters DONE.
- init_slow: clears pixel_index, pixel_bit_index, bit_pattern_index and the reset counter, sets state to IDLE, and pulses init_slow_done for exactly one cycle on the following edge. If init_slow is held high, the acknowledge repeats every other cycle.
- No combinational path from reg_* inputs to state. Strobes are combinational from registered state and inputs.
- No simulation-stop constructs.

Test Plan:
1. BUFFER_END=3, PIXEL_BITS=24, PATTERN_STEPS=8, run=1, loop=0, reg_reset_delay=10 -> TRANSMIT for 768 cycles, then RESET for 11 cycles, then DONE. frame_done pulses once and frame_count=1.
2. Same configuration with loop=1 for 3 frames -> frame_count=3. stream_pixel_of asserts exactly 3 times, each at pixel_index=3 with pixel_bit_index=23 and bit_pattern_index=7.
3. PIXEL_BITS=32, 32-bit mode, BUFFER_END=7 -> pixel_index sequence 0, 4, then wrap. Each pixel spans 256 cycles and the frame lasts 512 cycles.
4. limit=1, reg_max=100 with BUFFER_END=7 -> pixel_index_max=7. Then reg_max=2 -> pixel_index_max=2 and the frame covers 3 pixels.
5. Drop run for 50 cycles mid-pixel -> all indices frozen and stream_output=0. After run returns, the remaining cycle count is unchanged.
6. Assert rst mid-RESET -> all outputs return to reset values immediately. Pulse init_slow during TRANSMIT -> indices 0, state IDLE, init_slow_done high for exactly 1 cycle.
